multicycle_control: RTL and testbench

- Moore main-control FSM for the multicycle 32-bit MIPS datapath.
- Sequences the shared ALU, memory, IR, PC and register file across fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALU operation code directly and consumes the ALU Zero flag for BEQ.
- Sits between the instruction register (opcode/funct fields) and the datapath muxes/enables.

---
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Moore main-control FSM for the multicycle 32-bit MIPS datapath.
// Optional ADDI support is enabled by defining MULTICYCLE_ADDI_EN.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCEn,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic [1:0]         PCSource,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        S_INIT    = STATE_W'(0),
        S_FETCH   = STATE_W'(1),
        S_DECODE  = STATE_W'(2),
        S_MEMADR  = STATE_W'(3),
        S_MEMRD   = STATE_W'(4),
        S_MEMWB   = STATE_W'(5),
        S_MEMWR   = STATE_W'(6),
        S_REXE    = STATE_W'(7),
        S_RWB     = STATE_W'(8),
        S_BEQ     = STATE_W'(9),
        S_JUMP    = STATE_W'(10),
        S_ILLEGAL = STATE_W'(11),
        S_ADDIEX  = STATE_W'(12),
        S_ADDIWB  = STATE_W'(13)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    state_t state_q, state_d;
    logic   funct_ok;

    assign funct_ok = (Funct == FN_ADD) || (Funct == FN_SUB) ||
                      (Funct == FN_AND) || (Funct == FN_OR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_AND;
        PCSource    = 2'b00;
        Illegal     = 1'b0;

        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                MemRead    = 1'b1;
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                PCWrite    = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_ok ? S_REXE : S_ILLEGAL;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                state_d    = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_REXE: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    default: ALUControl = ALU_ADD;
                endcase
                state_d = S_RWB;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUControl  = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ILLEGAL: Illegal = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: RegWrite = 1'b1;
`endif
            // Unreachable encodings fall back to FETCH with all outputs idle.
            default: state_d = S_FETCH;
        endcase
    end

    assign PCEn  = PCWrite | (PCWriteCond & Zero);
    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and checks state plus the full control vector.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, ALUControl, PCSource;
    logic [3:0] State;

    int errors = 0;
    int checks = 0;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .PCSource(PCSource), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    // Control vector order:
    // PCWrite PCWriteCond PCEn IorD MemRead MemWrite IRWrite MemtoReg RegDst
    // RegWrite ALUSrcA ALUSrcB[1:0] ALUControl[1:0] PCSource[1:0] Illegal
    logic [17:0] obs_vec;
    assign obs_vec = {PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite,
                      IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                      ALUControl, PCSource, Illegal};

    function automatic logic [17:0] mk(
        input logic pcw, pcwc, pcen, iord, mr, mw, irw, m2r, rd, rw, asa,
        input logic [1:0] asb, aluc, pcs, input logic ill);
        return {pcw, pcwc, pcen, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aluc, pcs, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [17:0] v);
        step();
        $display("t=%0t %s state=%0d ctrl=%h", $time, tag, State, obs_vec);
        chk({tag, ".state"}, 32'(State), 32'(st));
        chk({tag, ".ctrl"}, 32'(obs_vec), 32'(v));
    endtask

    logic [17:0] V_FETCH, V_DECODE, V_MEMADR, V_IDLE;

    initial begin
        V_FETCH  = mk(1,0,1,0,1,0,1,0,0,0,0,2'b01,2'b10,2'b00,0);
        V_DECODE = mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b10,2'b00,0);
        V_MEMADR = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,0);
        V_IDLE   = '0;

        reset = 1'b1; Opcode = 6'h00; Funct = 6'h00; Zero = 1'b0;
        for (int i = 0; i < 3; i++) expect_cycle("reset", 4'd0, V_IDLE);
        reset = 1'b0;
        Opcode = 6'h23;
        expect_cycle("fetch_after_reset", 4'd1, V_FETCH);

        // lw: 1,2,3,4,5,1
        expect_cycle("lw.decode", 4'd2, V_DECODE);
        expect_cycle("lw.memadr", 4'd3, V_MEMADR);
        expect_cycle("lw.memrd", 4'd4, mk(0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0));
        expect_cycle("lw.memwb", 4'd5, mk(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0));
        Opcode = 6'h00; Funct = 6'h22;
        expect_cycle("lw.fetch", 4'd1, V_FETCH);

        // R-type SUB
        expect_cycle("sub.decode", 4'd2, V_DECODE);
        expect_cycle("sub.rexe", 4'd7, mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b11,2'b00,0));
        expect_cycle("sub.rwb", 4'd8, mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0));
        Funct = 6'h25;
        expect_cycle("sub.fetch", 4'd1, V_FETCH);

        // R-type OR
        expect_cycle("or.decode", 4'd2, V_DECODE);
        expect_cycle("or.rexe", 4'd7, mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b00,0));
        expect_cycle("or.rwb", 4'd8, mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0));
        Funct = 6'h27;
        expect_cycle("or.fetch", 4'd1, V_FETCH);

        // Unsupported funct (NOR)
        expect_cycle("nor.decode", 4'd2, V_DECODE);
        expect_cycle("nor.illegal", 4'd11, mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1));
        Opcode = 6'h04; Zero = 1'b1;
        expect_cycle("nor.fetch", 4'd1, V_FETCH);

        // beq taken
        expect_cycle("beq1.decode", 4'd2, V_DECODE);
        expect_cycle("beq1.beq", 4'd9, mk(0,1,1,0,0,0,0,0,0,0,1,2'b00,2'b11,2'b01,0));
        Zero = 1'b0;
        expect_cycle("beq1.fetch", 4'd1, V_FETCH);

        // beq not taken
        expect_cycle("beq0.decode", 4'd2, V_DECODE);
        expect_cycle("beq0.beq", 4'd9, mk(0,1,0,0,0,0,0,0,0,0,1,2'b00,2'b11,2'b01,0));
        Opcode = 6'h02;
        expect_cycle("beq0.fetch", 4'd1, V_FETCH);

        // jump
        expect_cycle("j.decode", 4'd2, V_DECODE);
        expect_cycle("j.jump", 4'd10, mk(1,0,1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0));
        Opcode = 6'h08;
        expect_cycle("j.fetch", 4'd1, V_FETCH);

        // addi
        expect_cycle("addi.decode", 4'd2, V_DECODE);
`ifdef MULTICYCLE_ADDI_EN
        expect_cycle("addi.ex", 4'd12, V_MEMADR);
        expect_cycle("addi.wb", 4'd13, mk(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0));
`else
        expect_cycle("addi.illegal", 4'd11, mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1));
`endif
        Opcode = 6'h2B;
        expect_cycle("addi.fetch", 4'd1, V_FETCH);

        // sw, then asynchronous reset while in MEMWR
        expect_cycle("sw.decode", 4'd2, V_DECODE);
        expect_cycle("sw.memadr", 4'd3, V_MEMADR);
        expect_cycle("sw.memwr", 4'd6, mk(0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0));
        reset = 1'b1;
        #1;
        $display("t=%0t async_reset state=%0d MemWrite=%0b", $time, State, MemWrite);
        chk("async_reset.state", 32'(State), 32'd0);
        chk("async_reset.memwrite", 32'(MemWrite), 32'd0);
        chk("async_reset.ctrl", 32'(obs_vec), 32'(V_IDLE));
        expect_cycle("reset_hold", 4'd0, V_IDLE);
        reset = 1'b0;
        Opcode = 6'h3F;
        expect_cycle("post_reset.fetch", 4'd1, V_FETCH);

        // Unknown opcode
        expect_cycle("op3f.decode", 4'd2, V_DECODE);
        expect_cycle("op3f.illegal", 4'd11, mk(0,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1));
        expect_cycle("op3f.fetch", 4'd1, V_FETCH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
